// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests, buffers
// returned instructions with their PCs and hands them to decode; redirects flush.
module fetch_unit_chk #(
    parameter int CW = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          imem_resp_valid,
    input logic [CW-1:0] outstanding
);
    resp_without_request: assert property (@(posedge clk) disable iff (!reset)
        imem_resp_valid |-> (outstanding != {CW{1'b0}}));
endmodule

module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc
);
    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   ZERO_C  = {CW{1'b0}};
    localparam logic [AW-1:0]   ZERO_P  = {AW{1'b0}};
    localparam logic [AW-1:0]   ONE_P   = AW'(1);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    typedef enum logic [0:0] {ST_FETCH = 1'b0, ST_DRAIN = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic            credit_s;
    logic            req_valid_s;
    logic            fire_s;
    logic            resp_ok_s;
    logic            push_s;
    logic            pop_s;
    logic [CW-1:0]   outst_left_s;
    logic [XLEN-1:0] target_s;

    // Handshake qualification; a response with nothing in flight is ignored.
    always_comb begin
        credit_s     = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W;
        req_valid_s  = reset && (state_q == ST_FETCH) && credit_s && !redirect_valid;
        fire_s       = req_valid_s && imem_req_ready;
        resp_ok_s    = imem_resp_valid && (outst_q != ZERO_C);
        push_s       = resp_ok_s && (state_q == ST_FETCH) && !redirect_valid;
        pop_s        = (count_q != ZERO_C) && dec_ready;
        outst_left_s = outst_q - CW'(resp_ok_s);
        target_s     = {redirect_pc[XLEN-1:2], 2'b00};
    end

    // Next-state: redirect overrides every other update in its cycle.
    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        outst_d   = outst_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        state_d   = state_q;
        if (redirect_valid) begin
            pc_d      = target_s;
            resp_pc_d = target_s;
            outst_d   = outst_left_s;
            count_d   = ZERO_C;
            wr_ptr_d  = ZERO_P;
            rd_ptr_d  = ZERO_P;
            state_d   = (outst_left_s != ZERO_C) ? ST_DRAIN : ST_FETCH;
        end else begin
            outst_d = outst_left_s + CW'(fire_s);
            count_d = count_q + CW'(push_s) - CW'(pop_s);
            if (fire_s) begin
                pc_d = pc_q + STEP;
            end else begin
                pc_d = pc_q;
            end
            if (push_s) begin
                resp_pc_d = resp_pc_q + STEP;
                wr_ptr_d  = wr_ptr_q + ONE_P;
            end else begin
                resp_pc_d = resp_pc_q;
                wr_ptr_d  = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + ONE_P;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case (state_q)
                ST_FETCH: state_d = ST_FETCH;
                ST_DRAIN: state_d = (outst_left_s == ZERO_C) ? ST_FETCH : ST_DRAIN;
                default:  state_d = ST_FETCH;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= ZERO_C;
            count_q   <= ZERO_C;
            wr_ptr_q  <= ZERO_P;
            rd_ptr_q  <= ZERO_P;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= {XLEN{1'b0}};
                pc_mem_q[i]    <= {XLEN{1'b0}};
            end
        end else if (push_s) begin
            instr_mem_q[wr_ptr_q] <= imem_resp_data;
            pc_mem_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q;
    assign dec_valid      = (count_q != ZERO_C);
    assign dec_instr      = instr_mem_q[rd_ptr_q];
    assign dec_pc         = pc_mem_q[rd_ptr_q];

    fetch_unit_chk #(.CW(CW)) u_chk (
        .clk             (clk),
        .reset           (reset),
        .imem_resp_valid (imem_resp_valid),
        .outstanding     (outst_q)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: an in-order memory model with variable latency
// drives the DUT, and a queue-based reference model predicts every output each cycle.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] addr; int cyc; } fire_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // reference model
    ent_t        m_fifo[$];
    int          m_out;
    bit          m_drain;
    logic [31:0] m_pc;
    logic [31:0] m_resp_pc;
    bit          m_req_valid;

    // memory model and observation logs
    mreq_t       mem_q[$];
    int          last_due;
    fire_t       fire_log[$];
    logic [31:0] hs_log[$];

    // stimulus knobs
    int          k_ready_pct = 100;
    int          k_dec_pct = 100;
    int          k_lat_min = 1;
    int          k_lat_max = 1;
    int          k_redir_pm = 0;
    bit          f_redir = 1'b0;
    logic [31:0] f_redir_pc = 32'h0;

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        m_req_valid = !m_drain && (m_fifo.size() + m_out < DEPTH) && !redirect_valid;
        cmp("req_valid", 32'(imem_req_valid), 32'(m_req_valid));
        if (m_req_valid) cmp("req_addr", imem_req_addr, m_pc);
        cmp("dec_valid", 32'(dec_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            cmp("dec_pc", dec_pc, m_fifo[0].pc);
            cmp("dec_instr", dec_instr, m_fifo[0].data);
        end
        if (imem_req_valid && imem_req_ready) fire_log.push_back('{imem_req_addr, cyc});
        if (dec_valid && dec_ready) hs_log.push_back(dec_pc);
    endtask

    task automatic model_update();
        bit  resp_ok;
        bit  fire;
        int  due;
        resp_ok = imem_resp_valid && (m_out > 0);
        fire    = m_req_valid && imem_req_ready;
        if (fire) begin
            due = cyc + $urandom_range(k_lat_min, k_lat_max);
            if (due <= last_due) due = last_due + 1;
            mem_q.push_back('{m_pc, due});
            last_due = due;
        end
        if (m_fifo.size() != 0 && dec_ready) void'(m_fifo.pop_front());
        if (redirect_valid) begin
            m_pc      = {redirect_pc[31:2], 2'b00};
            m_resp_pc = m_pc;
            m_fifo.delete();
            if (resp_ok) m_out--;
            m_drain = (m_out > 0);
        end else begin
            if (fire) begin
                m_pc = m_pc + 32'd4;
                m_out++;
            end
            if (resp_ok) begin
                m_out--;
                if (!m_drain) begin
                    m_fifo.push_back('{m_resp_pc, imem_resp_data});
                    m_resp_pc = m_resp_pc + 32'd4;
                end
            end
            if (m_drain && m_out == 0) m_drain = 1'b0;
        end
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step();
        mreq_t r;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(r.addr);
        end
        imem_req_ready = ($urandom_range(0, 99) < k_ready_pct);
        dec_ready      = ($urandom_range(0, 99) < k_dec_pct);
        if (f_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = f_redir_pc;
            f_redir        = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(0, 999) < k_redir_pm);
            redirect_pc    = $urandom;
        end
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
        dec_ready       = 1'b0;
        #1;
        cmp("rst_req_valid", 32'(imem_req_valid), 32'd0);
        cmp("rst_dec_valid", 32'(dec_valid), 32'd0);
        cmp("rst_dec_pc", dec_pc, 32'h0);
        cmp("rst_dec_instr", dec_instr, 32'h0);
        cmp("rst_req_addr", imem_req_addr, 32'h0);
        mem_q.delete();
        m_fifo.delete();
        m_out     = 0;
        m_drain   = 1'b0;
        m_pc      = 32'h0;
        m_resp_pc = 32'h0;
        last_due  = -1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
        fire_log.delete();
        hs_log.delete();
    endtask

    task automatic knobs(int rdy, int dec, int lmin, int lmax, int rpm);
        k_ready_pct = rdy;
        k_dec_pct   = dec;
        k_lat_min   = lmin;
        k_lat_max   = lmax;
        k_redir_pm  = rpm;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int base;
        #2;

        // 1: streaming after reset release
        do_reset();
        knobs(100, 100, 1, 1, 0);
        run(8);
        cmp("t1_fire_cnt_ge4", 32'(fire_log.size() >= 4), 32'd1);
        if (fire_log.size() >= 4) begin
            cmp("t1_first_fire_cyc", 32'(fire_log[0].cyc), 32'd0);
            for (int i = 0; i < 4; i++) cmp("t1_fire_addr", fire_log[i].addr, 32'(4 * i));
        end
        cmp("t1_hs_cnt_ge4", 32'(hs_log.size() >= 4), 32'd1);
        if (hs_log.size() >= 4)
            for (int i = 0; i < 4; i++) cmp("t1_dec_pc", hs_log[i], 32'(4 * i));

        // 2: backpressure caps requests at DEPTH; one pop frees one credit
        do_reset();
        knobs(100, 0, 1, 1, 0);
        run(10);
        cmp("t2_fires_full", 32'(fire_log.size()), 32'd4);
        cmp("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
        k_dec_pct = 100;
        run(1);
        k_dec_pct = 0;
        run(8);
        cmp("t2_fires_after_pop", 32'(fire_log.size()), 32'd5);

        // 3: redirect with two requests in flight drains them
        do_reset();
        knobs(100, 100, 4, 4, 0);
        run(2);
        f_redir = 1'b1;
        f_redir_pc = 32'h103;
        run(1);
        run(10);
        idx = -1;
        for (int i = 0; i < fire_log.size(); i++)
            if (idx < 0 && fire_log[i].cyc > 2) idx = i;
        cmp("t3_refetch_seen", 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
            cmp("t3_refetch_cyc", 32'(fire_log[idx].cyc), 32'd6);
            cmp("t3_refetch_addr", fire_log[idx].addr, 32'h100);
        end
        cmp("t3_hs_seen", 32'(hs_log.size() > 0), 32'd1);
        if (hs_log.size() > 0) cmp("t3_first_dec_pc", hs_log[0], 32'h100);

        // 4: redirect coinciding with a pop and a response
        do_reset();
        knobs(100, 0, 1, 1, 0);
        run(3);
        k_dec_pct = 100;
        f_redir = 1'b1;
        f_redir_pc = 32'h200;
        run(1);
        cmp("t4_pop_count", 32'(hs_log.size()), 32'd1);
        if (hs_log.size() > 0) cmp("t4_pop_pc", hs_log[0], 32'h0);
        cmp("t4_fifo_empty", 32'(dec_valid), 32'd0);
        run(4);
        idx = -1;
        for (int i = 0; i < fire_log.size(); i++)
            if (idx < 0 && fire_log[i].cyc > 3) idx = i;
        cmp("t4_refetch_seen", 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
            cmp("t4_refetch_cyc", 32'(fire_log[idx].cyc), 32'd4);
            cmp("t4_refetch_addr", fire_log[idx].addr, 32'h200);
        end

        // 5a: PC wraps modulo 2^32
        do_reset();
        knobs(100, 100, 1, 1, 0);
        run(3);
        f_redir = 1'b1;
        f_redir_pc = 32'hFFFF_FFFA;
        run(1);
        base = hs_log.size();
        run(12);
        cmp("t5_wrap_cnt", 32'(hs_log.size() >= base + 3), 32'd1);
        if (hs_log.size() >= base + 3) begin
            cmp("t5_wrap0", hs_log[base], 32'hFFFF_FFF8);
            cmp("t5_wrap1", hs_log[base + 1], 32'hFFFF_FFFC);
            cmp("t5_wrap2", hs_log[base + 2], 32'h0000_0000);
        end

        // 5b: random ready and latency, no redirects: strictly +4 stream
        knobs(50, 70, 1, 5, 0);
        hs_log.delete();
        run(800);
        cmp("t5_progress", 32'(hs_log.size() > 100), 32'd1);
        for (int i = 1; i < hs_log.size(); i++)
            cmp("t5_pc_step", hs_log[i], hs_log[i - 1] + 32'd4);

        // 5c: random traffic with occasional redirects
        knobs(60, 70, 1, 6, 20);
        run(1500);

        // 6: reset asserted mid-drain
        do_reset();
        knobs(100, 100, 6, 6, 0);
        run(2);
        f_redir = 1'b1;
        f_redir_pc = 32'h40;
        run(2);
        reset = 1'b0;
        #1;
        cmp("t6_req_valid_now", 32'(imem_req_valid), 32'd0);
        cmp("t6_dec_valid_now", 32'(dec_valid), 32'd0);
        do_reset();
        knobs(100, 100, 1, 1, 0);
        run(3);
        cmp("t6_restart_seen", 32'(fire_log.size() > 0), 32'd1);
        if (fire_log.size() > 0) begin
            cmp("t6_restart_addr", fire_log[0].addr, 32'h0);
            cmp("t6_restart_cyc", 32'(fire_log[0].cyc), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
